lbist_ctrl: RTL

LBIST_CTRL -- requirements
Module: lbist_ctrl

---
 rtl/lbist_pkg.sv | 43 ++++
 rtl/lbist_lfsr.sv | 42 ++++
 rtl/lbist_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/lbist_pkg.sv
// Shared types and constants for the LBIST campaign controller: FSM states,
// counter widths and the maximal-length LFSR tap table.
package lbist_pkg;

    localparam int CNT_W = 16;
    localparam int PAT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INJECT,
        S_CHECK,
        S_APPLY,
        S_RECORD,
        S_FINISH
    } state_e;

    // Tap masks for a left-shifting Fibonacci LFSR; bit k-1 set means tap k.
    function automatic logic [15:0] lfsr_taps(input int width);
        case (width)
            2:       return 16'h0003;
            3:       return 16'h0006;
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/lbist_lfsr.sv
// Maximal-length Fibonacci LFSR pattern generator with synchronous load and
// step controls; resets to RST_VAL.
module lbist_lfsr
    import lbist_pkg::*;
#(
    parameter int                 WIDTH   = 5,
    parameter logic [WIDTH-1:0]   RST_VAL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

    logic [WIDTH-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = seed;
        end else if (step) begin
            q_d = {q_q[WIDTH-2:0], ^(q_q & TAPS)};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/lbist_ctrl.sv
// LBIST campaign controller: per injected fault, applies LFSR patterns to the
// faulty and fault-free CUTs and counts detections. Define LBIST_EARLY_EXIT_EN
// to end a fault's pattern burst on the cycle after its first mismatch.
module lbist_ctrl
    import lbist_pkg::*;
#(
    parameter int IN_BITS  = 5,
    parameter int OUT_BITS = 2,
    parameter int PAT_CNT  = 31,
    parameter int SEED     = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                FIL_INC,
    input  logic                FIL_END,
    output logic [IN_BITS-1:0]  TEST_IP,
    input  logic [OUT_BITS-1:0] CUT_OP,
    input  logic [OUT_BITS-1:0] FF_OP,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    faults_total,
    output logic [CNT_W-1:0]    faults_det
);

    localparam logic [IN_BITS-1:0] SEED_V   = IN_BITS'(SEED);
    localparam logic [PAT_W-1:0]   LAST_PAT = PAT_W'(PAT_CNT - 1);

    state_e             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   tot_q, tot_d;
    logic [CNT_W-1:0]   det_q, det_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic               flag_q, flag_d;
    logic               lfsr_load, lfsr_step;
    logic [IN_BITS-1:0] lfsr_q;
    logic               mismatch, leave_apply;

    lbist_lfsr #(
        .WIDTH   (IN_BITS),
        .RST_VAL (SEED_V)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .step (lfsr_step),
        .seed (SEED_V),
        .q    (lfsr_q)
    );

    assign mismatch = (CUT_OP != FF_OP);

`ifdef LBIST_EARLY_EXIT_EN
    assign leave_apply = (pat_q == LAST_PAT) || mismatch;
`else
    assign leave_apply = (pat_q == LAST_PAT);
`endif

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = done_q;
        tot_d     = tot_q;
        det_d     = det_q;
        pat_d     = pat_q;
        flag_d    = flag_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        FIL_INC   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    tot_d   = '0;
                    det_d   = '0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_INJECT;
                end
            end
            S_INJECT: begin
                FIL_INC = 1'b1;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (FIL_END) begin
                    state_d = S_FINISH;
                end else begin
                    lfsr_load = 1'b1;
                    pat_d     = '0;
                    flag_d    = 1'b0;
                    state_d   = S_APPLY;
                end
            end
            S_APPLY: begin
                lfsr_step = 1'b1;
                pat_d     = pat_q + 1'b1;
                flag_d    = flag_q | mismatch;
                if (leave_apply) state_d = S_RECORD;
            end
            S_RECORD: begin
                // flag_q already holds the last APPLY cycle's compare result.
                tot_d = sat_inc(tot_q);
                if (flag_q) det_d = sat_inc(det_q);
                state_d = S_INJECT;
            end
            S_FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tot_q   <= '0;
            det_q   <= '0;
            pat_q   <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tot_q   <= tot_d;
            det_q   <= det_d;
            pat_q   <= pat_d;
            flag_q  <= flag_d;
        end
    end

    assign TEST_IP      = (state_q == S_APPLY) ? lfsr_q : '0;
    assign busy         = busy_q;
    assign done         = done_q;
    assign faults_total = tot_q;
    assign faults_det   = det_q;

endmodule
